// File: rtl/updown_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : updown_mod_counter
//  Purpose  : Loadable up/down modulo counter. Counts over 0..MAX_COUNT and
//             raises a one-cycle terminal-count pulse (tc) on every edge that
//             crosses a range boundary. By default a boundary crossing wraps
//             (MAX_COUNT -> 0 going up, 0 -> MAX_COUNT going down). When the
//             macro UDC_SATURATE_EN is defined, a boundary crossing holds the
//             value at the limit instead, still pulsing tc on every attempt.
//  Ports    : clk      - single clock, all state updates on posedge
//             reset    - asynchronous, active-low reset (clears count and tc)
//             load     - load data_in this edge (clamped to MAX_COUNT)
//             ud       - count direction: 1 = up, 0 = down
//             en       - count enable, ignored while load = 1
//             data_in  - load value
//             data_out - registered count value
//             tc       - registered terminal-count pulse
//  Params   : WIDTH (4), MAX_COUNT (11, legal 1 .. 2**WIDTH-1)
//  Macro    : UDC_SATURATE_EN (saturate instead of wrap at the boundaries)
//  Revision : 1.0 - initial release
// ============================================================================
module updown_mod_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             ud,
  input  logic             en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             tc
);

  // --------------------------------------------------------------------------
  // Elaboration-time range check on the count limit
  // --------------------------------------------------------------------------
  generate
    if ((MAX_COUNT < 1) || (MAX_COUNT > (2**WIDTH) - 1)) begin : g_bad_max_count
      $error("updown_mod_counter: MAX_COUNT out of range 1 .. 2**WIDTH-1");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ZERO_VAL = '0;
  localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

  // Values produced when a boundary is crossed; this is the only place the
  // two builds differ.
`ifdef UDC_SATURATE_EN
  localparam logic [WIDTH-1:0] UP_BOUND_VAL   = MAX_VAL;
  localparam logic [WIDTH-1:0] DOWN_BOUND_VAL = ZERO_VAL;
`else
  localparam logic [WIDTH-1:0] UP_BOUND_VAL   = ZERO_VAL;
  localparam logic [WIDTH-1:0] DOWN_BOUND_VAL = MAX_VAL;
`endif

  // --------------------------------------------------------------------------
  // Phase FSM: BOUND marks that the last edge was a boundary event, which is
  // exactly when tc must be high.
  // --------------------------------------------------------------------------
  localparam logic [0:0] S_COUNT = 1'b0;
  localparam logic [0:0] S_BOUND = 1'b1;

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;

  logic             at_max;
  logic             at_zero;
  logic             boundary;
  logic [WIDTH-1:0] load_val;

  assign at_max  = (count == MAX_VAL);
  assign at_zero = (count == ZERO_VAL);

  // A boundary event needs a real count step (not a load) hitting the limit
  // in the current direction.
  assign boundary = ~load & en & (ud ? at_max : at_zero);

  // Out-of-range loads are clamped so the count never leaves 0..MAX_COUNT.
  assign load_val = (data_in > MAX_VAL) ? MAX_VAL : data_in;

  // --------------------------------------------------------------------------
  // State register (FSM state and count value)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_COUNT;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = S_COUNT;
    case (state)
      S_COUNT: state_next = boundary ? S_BOUND : S_COUNT;
      S_BOUND: state_next = boundary ? S_BOUND : S_COUNT;
      default: state_next = S_COUNT;
    endcase
  end

  // Count datapath: priority load > en > hold.
  always_comb begin
    count_next = count;
    if (load) begin
      count_next = load_val;
    end else if (en) begin
      if (ud) begin
        count_next = at_max ? UP_BOUND_VAL : (count + ONE_VAL);
      end else begin
        count_next = at_zero ? DOWN_BOUND_VAL : (count - ONE_VAL);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output logic (both outputs come straight from registers)
  // --------------------------------------------------------------------------
  always_comb begin
    data_out = count;
    tc       = (state == S_BOUND);
  end

endmodule
`default_nettype wire

// File: tb/tb_updown_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_updown_mod_counter
//  Purpose  : Self-checking bench for updown_mod_counter. Stimulus drives the
//             inputs on the falling edge and pushes the reference model's
//             expected outputs into a queue; a monitor pops one entry after
//             each rising edge and compares it with data_out/tc.
//  Macro    : UDC_SATURATE_EN selects the saturating reference behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_updown_mod_counter;

  localparam int WIDTH     = 4;
  localparam int MAX_COUNT = 11;

  logic             clk;
  logic             reset;
  logic             load;
  logic             ud;
  logic             en;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             tc;

  typedef struct {
    int    cnt;
    bit    tc;
    string tag;
  } exp_t;

  exp_t exp_q[$];

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model state
  int m_cnt = 0;
  bit m_tc  = 1'b0;

  updown_mod_counter #(
    .WIDTH    (WIDTH),
    .MAX_COUNT(MAX_COUNT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .ud      (ud),
    .en      (en),
    .data_in (data_in),
    .data_out(data_out),
    .tc      (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: counting is modular arithmetic over MAX_COUNT+1 values; a
  // boundary event is a step that would leave the range.
  task automatic model_step(input bit rst_n, input bit ld, input bit up,
                            input bit ena, input int din);
    int range;
    range = MAX_COUNT + 1;
    if (!rst_n) begin
      m_cnt = 0;
      m_tc  = 1'b0;
    end else if (ld) begin
      m_cnt = (din > MAX_COUNT) ? MAX_COUNT : din;
      m_tc  = 1'b0;
    end else if (ena) begin
      if (up) begin
        m_tc = (m_cnt + 1 > MAX_COUNT);
`ifdef UDC_SATURATE_EN
        if (!m_tc) m_cnt = m_cnt + 1;
`else
        m_cnt = (m_cnt + 1) % range;
`endif
      end else begin
        m_tc = (m_cnt - 1 < 0);
`ifdef UDC_SATURATE_EN
        if (!m_tc) m_cnt = m_cnt - 1;
`else
        m_cnt = (m_cnt - 1 + range) % range;
`endif
      end
    end else begin
      m_tc = 1'b0;
    end
  endtask

  // One clock of stimulus: drive on the falling edge, push the expectation.
  task automatic step(input bit rst_n, input bit ld, input bit up,
                      input bit ena, input int din, input string tag);
    exp_t e;
    @(negedge clk);
    reset   = rst_n;
    load    = ld;
    ud      = up;
    en      = ena;
    data_in = WIDTH'(din);
    model_step(rst_n, ld, up, ena, din);
    e.cnt = m_cnt;
    e.tc  = m_tc;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: one output sample per rising edge while expectations are queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_compared++;
        if ((int'(data_out) != e.cnt) || (tc !== e.tc)) begin
          n_mismatched++;
          $display("FAIL %s: data_out=%0d tc=%0b, required data_out=%0d tc=%0b at %0t",
                   e.tag, data_out, tc, e.cnt, e.tc, $time);
        end
      end
    end
  end

  // Immediate (clock-independent) check for the asynchronous reset.
  task automatic check_now(input int cnt, input bit t, input string tag);
    n_compared++;
    if ((int'(data_out) != cnt) || (tc !== t)) begin
      n_mismatched++;
      $display("FAIL %s: data_out=%0d tc=%0b, required data_out=%0d tc=%0b",
               tag, data_out, tc, cnt, t);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    int din;
    int waits;
    reset   = 1'b0;
    load    = 1'b0;
    ud      = 1'b0;
    en      = 1'b0;
    data_in = '0;
    #1;
    check_now(0, 1'b0, "reset_state");

    step(1'b0, 0, 0, 0, 0, "reset_hold");
    step(1'b0, 0, 0, 0, 0, "reset_hold");

    // Async reset mid-operation
    step(1'b1, 1, 0, 0, 7, "load7");
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_now(0, 1'b0, "async_reset");
    model_step(1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1, 1, 1, 9, "reset_held");

    // Load and clamp
    step(1'b1, 1, 0, 0, 5,  "load5");
    step(1'b1, 1, 0, 0, 14, "load_clamp");
    step(1'b1, 1, 1, 1, 3,  "load_over_en");

    // Up across the top boundary
    step(1'b1, 1, 0, 0, 10, "load10");
    for (int i = 0; i < 3; i++) step(1'b1, 0, 1, 1, 0, "up_boundary");

    // Down across the bottom boundary
    step(1'b1, 1, 0, 0, 1, "load1");
    for (int i = 0; i < 3; i++) step(1'b1, 0, 0, 1, 0, "down_boundary");

    // Hold and direction flips
    step(1'b1, 1, 0, 0, 4, "load4");
    step(1'b1, 0, 1, 0, 0, "hold");
    step(1'b1, 0, 0, 0, 0, "hold");
    step(1'b1, 0, 1, 1, 0, "flip_up");
    step(1'b1, 0, 0, 1, 0, "flip_down");
    step(1'b1, 0, 1, 1, 0, "flip_up");

    // Repeated boundary attempts at both limits
    step(1'b1, 1, 0, 0, 11, "load11");
    step(1'b1, 0, 1, 1, 0, "up_at_max");
    step(1'b1, 0, 1, 1, 0, "up_at_max2");
    step(1'b1, 1, 0, 0, 0, "load0");
    step(1'b1, 0, 0, 1, 0, "down_at_zero");
    step(1'b1, 0, 0, 1, 0, "down_at_zero2");

    // Randomized traffic, enable biased high to reach the boundaries often
    for (int i = 0; i < 400; i++) begin
      din = int'($urandom_range(0, (1 << WIDTH) - 1));
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 9) == 0),
           $urandom_range(0, 1),
           ($urandom_range(0, 3) != 0),
           din, "random");
    end

    waits = 0;
    while (exp_q.size() > 0 && waits < 20) begin
      @(posedge clk);
      waits++;
    end
    @(negedge clk);
    if (exp_q.size() > 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire
